// File: rtl/pkg_dtypes.sv
// rtl/pkg_dtypes.sv - shared instruction-queue types, defaults and operand format rule
package pkg_dtypes;

  localparam int IQUEUE_DEPTH_DEFAULT = 8;
  localparam int IQUEUE_CNT_W         = $clog2(IQUEUE_DEPTH_DEFAULT) + 1;

  typedef enum logic [1:0] {
    IMM_OR_NONE = 2'b00,
    OPM_REG     = 2'b01,
    OPM_FWD     = 2'b10,
    OPM_MEM     = 2'b11
  } type_opmode;

  typedef struct packed {
    logic [3:0]  zero;
    logic [11:0] imm;
  } type_imm_operand;

  typedef struct packed {
    logic [11:0] pad;
    logic [3:0]  idx;
  } type_reg_operand;

  typedef union packed {
    type_imm_operand as_imm;
    type_reg_operand as_reg;
  } type_operand;

  typedef struct packed {
    logic [5:0]  opcode;
    type_opmode  op0m;
    type_operand op0;
    type_opmode  op1m;
    type_operand op1;
  } type_iqueue_entry;

  localparam int IQUEUE_ENTRY_W = $bits(type_iqueue_entry);

  typedef struct packed {
    logic [IQUEUE_CNT_W-1:0] count;
    logic                    almost_full;
    logic                    fmt_err;
  } type_iqueue_status;

  // Immediate operands must keep their padding nibble clear.
  function automatic logic entry_fmt_bad(type_iqueue_entry e);
    return ((e.op0m == IMM_OR_NONE) && (e.op0.as_imm.zero != 4'd0)) ||
           ((e.op1m == IMM_OR_NONE) && (e.op1.as_imm.zero != 4'd0));
  endfunction

endpackage

// File: rtl/iqueue_fifo_imm_check.sv
// rtl/iqueue_fifo_imm_check.sv - combinational immediate-operand format checker for one entry
module iqueue_imm_check
  import pkg_dtypes::*;
(
  input  logic [IQUEUE_ENTRY_W-1:0] i_entry,
  output logic                      o_err
);

  assign o_err = entry_fmt_bad(type_iqueue_entry'(i_entry));

endmodule

// File: rtl/iqueue_fifo.sv
// rtl/iqueue_fifo.sv - instruction queue between decode and issue with flush and format check
// Optional same-cycle empty-queue bypass enabled by defining IQUEUE_BYPASS_EN.
module iqueue_fifo
  import pkg_dtypes::*;
#(
  parameter int DEPTH        = IQUEUE_DEPTH_DEFAULT,
  parameter int AFULL_THRESH = 6,
  parameter int LOG2_DEPTH   = $clog2(DEPTH)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_enq_valid,
  input  logic [IQUEUE_ENTRY_W-1:0] i_enq_entry,
  output logic                      o_enq_ready,
  output logic                      o_deq_valid,
  output logic [IQUEUE_ENTRY_W-1:0] o_deq_entry,
  input  logic                      i_deq_ready,
  input  logic                      i_flush,
  output logic [LOG2_DEPTH:0]       o_count,
  output logic                      o_almost_full,
  output logic                      o_fmt_err
);

  localparam logic [LOG2_DEPTH:0]   CNT_FULL  = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0]   CNT_AFULL = (LOG2_DEPTH+1)'(AFULL_THRESH);
  localparam logic [LOG2_DEPTH:0]   CNT_ONE   = (LOG2_DEPTH+1)'(1);
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE   = (LOG2_DEPTH)'(1);

  logic [IQUEUE_ENTRY_W-1:0] r_mem [DEPTH];
  logic [LOG2_DEPTH-1:0]     r_wr_ptr;
  logic [LOG2_DEPTH-1:0]     r_rd_ptr;
  logic [LOG2_DEPTH:0]       r_count;
  logic                      r_fmt_err;

  logic w_full;
  logic w_empty;
  logic w_enq_fire;
  logic w_deq_fire;
  logic w_bypass;
  logic w_bypass_take;
  logic w_push;
  logic w_pop;
  logic w_imm_err;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

`ifdef IQUEUE_BYPASS_EN
  assign w_bypass = w_empty & i_enq_valid & ~i_flush & ~i_reset;
`else
  assign w_bypass = 1'b0;
`endif

  assign o_enq_ready   = ~w_full & ~i_flush & ~i_reset;
  assign o_deq_valid   = (~w_empty | w_bypass) & ~i_flush;
  assign o_deq_entry   = w_bypass ? i_enq_entry : r_mem[r_rd_ptr];
  assign o_count       = r_count;
  assign o_almost_full = (r_count >= CNT_AFULL);
  assign o_fmt_err     = r_fmt_err;

  assign w_enq_fire    = i_enq_valid & o_enq_ready;
  assign w_deq_fire    = o_deq_valid & i_deq_ready;
  // A bypassed entry consumed in the same cycle never touches storage.
  assign w_bypass_take = w_bypass & i_deq_ready;
  assign w_push        = w_enq_fire & ~w_bypass_take;
  assign w_pop         = w_deq_fire & ~w_bypass_take;

  iqueue_imm_check u_imm_check (
    .i_entry (i_enq_entry),
    .o_err   (w_imm_err)
  );

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_enq_entry;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky until reset; a flush deliberately leaves it set.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fmt_err <= 1'b0;
    end else if (w_enq_fire & w_imm_err) begin
      r_fmt_err <= 1'b1;
    end
  end

  a_count_bound: assert property (@(posedge i_clk) disable iff (i_reset) r_count <= CNT_FULL);
  a_no_underflow: assert property (@(posedge i_clk) disable iff (i_reset) !(w_pop && w_empty));
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset) !(w_push && w_full));

endmodule
